// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite read path and the sprite RAM instance.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_EMIT
  } state_t;

  localparam int DEF_WORD_SIZE  = 32;
  localparam int DEF_NUM_WORDS  = 16;
  localparam int DEF_ADDR_BITS  = 4;
  localparam int DEF_PIXEL_BITS = 2;

  // Pixels packed into one row word.
  function automatic int ppw(input int word_size, input int pixel_bits);
    return word_size / pixel_bits;
  endfunction

endpackage

// File: rtl/sprite_row_reader.sv
// Fetches one sprite row from synchronous RAM and streams it MSB-first as
// PIXEL_BITS-wide pixels over a valid/ready handshake.
module sprite_row_reader
  import sprite_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int PIXEL_BITS = DEF_PIXEL_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_BITS-1:0]  i_row,
  output logic [ADDR_BITS-1:0]  o_mem_addr,
  input  logic [WORD_SIZE-1:0]  i_mem_data,
  output logic                  o_pixel_valid,
  output logic [PIXEL_BITS-1:0] o_pixel_data,
  input  logic                  i_pixel_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int PPW = ppw(WORD_SIZE, PIXEL_BITS);
  localparam int CW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [CW-1:0] LAST = CW'(PPW - 1);

  if (WORD_SIZE % PIXEL_BITS != 0) begin : g_bad_pixel_bits
    $error("PIXEL_BITS must divide WORD_SIZE");
  end

  state_t                r_state, w_state_nx;
  logic [ADDR_BITS-1:0]  r_addr,  w_addr_nx;
  logic [WORD_SIZE-1:0]  r_shift, w_shift_nx;
  logic [CW-1:0]         r_cnt,   w_cnt_nx;
  logic                  r_valid, w_valid_nx;
  logic                  r_done,  w_done_nx;
  logic                  r_err,   w_err_nx;
  logic                  w_row_ok;
  logic                  w_fire;

  assign w_row_ok = 32'(i_row) < 32'(NUM_WORDS);
  assign w_fire   = r_valid & i_pixel_ready;

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_shift_nx = r_shift;
    w_cnt_nx   = r_cnt;
    w_valid_nx = r_valid;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (w_row_ok) begin
            w_addr_nx  = i_row;
            w_state_nx = ST_FETCH;
          end else begin
            w_err_nx = 1'b1;
          end
        end
      end
      // RAM registers mem_addr at the edge leaving FETCH.
      ST_FETCH: w_state_nx = ST_CAPTURE;
      ST_CAPTURE: begin
        w_shift_nx = i_mem_data;
        w_cnt_nx   = '0;
        w_valid_nx = 1'b1;
        w_state_nx = ST_EMIT;
      end
      ST_EMIT: begin
        if (w_fire) begin
          w_shift_nx = r_shift << PIXEL_BITS;
          w_cnt_nx   = r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            w_valid_nx = 1'b0;
            w_done_nx  = 1'b1;
            w_state_nx = ST_IDLE;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_shift <= w_shift_nx;
      r_cnt   <= w_cnt_nx;
      r_valid <= w_valid_nx;
      r_done  <= w_done_nx;
      r_err   <= w_err_nx;
    end
  end

  assign o_mem_addr    = r_addr;
  assign o_pixel_valid = r_valid;
  assign o_pixel_data  = r_shift[WORD_SIZE-1 -: PIXEL_BITS];
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule
